// File: rtl/sync_fifo_mc.sv
// sync_fifo_mc: single-clock multi-channel FIFO. NUM_CH independent FIFOs of
// DEPTH entries share one storage array, one write port and one read port.
//
// Ports:
//   clk          - clock, rising edge
//   hwrst        - asynchronous active-low hard reset
//   sw_rst       - synchronous soft reset (pointers, flags, errors, rvalid)
//   wr_en/wr_ch/wdata  - write request, channel, data
//   rd_en/rd_ch        - read request, channel
//   rdata/rvalid       - read data, qualified by one-cycle rvalid pulse
//   full/empty/almost_full/almost_empty - per-channel registered flags
//   wr_overflow/rd_underflow            - per-channel error bits
//   err_clr      - synchronous clear of all error bits
//
// Optional feature: define SYNC_FIFO_MC_RD_PIPE_EN to add an output register
// stage after the storage read (read latency 2 instead of 1).
module sync_fifo_mc #(
  parameter int unsigned  DATA_WIDTH   = 32,
  parameter int unsigned  DEPTH        = 16,
  parameter int unsigned  NUM_CH       = 4,
  parameter int unsigned  AF_LEVEL     = DEPTH - 2,
  parameter int unsigned  AE_LEVEL     = 2,
  parameter bit           STICKY_ERROR = 1'b1,
  localparam int unsigned AW           = $clog2(DEPTH),
  localparam int unsigned CW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  hwrst,
  input  logic                  sw_rst,
  input  logic                  wr_en,
  input  logic [CW-1:0]         wr_ch,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  input  logic [CW-1:0]         rd_ch,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic [NUM_CH-1:0]     full,
  output logic [NUM_CH-1:0]     empty,
  output logic [NUM_CH-1:0]     almost_full,
  output logic [NUM_CH-1:0]     almost_empty,
  output logic [NUM_CH-1:0]     wr_overflow,
  output logic [NUM_CH-1:0]     rd_underflow,
  input  logic                  err_clr
);

  localparam int unsigned MemDepth = (2 ** CW) * DEPTH;

  typedef logic [AW:0] ptr_t;
  localparam ptr_t AfLevel = ptr_t'(AF_LEVEL);
  localparam ptr_t AeLevel = ptr_t'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [MemDepth];

  ptr_t wptr_q [NUM_CH];
  ptr_t wptr_d [NUM_CH];
  ptr_t rptr_q [NUM_CH];
  ptr_t rptr_d [NUM_CH];
  ptr_t level  [NUM_CH];

  logic [NUM_CH-1:0] full_q, full_d, empty_q, empty_d;
  logic [NUM_CH-1:0] afull_q, afull_d, aempty_q, aempty_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d, udf_q, udf_d, ovf_new, udf_new;

  logic                  wr_ch_ok, rd_ch_ok;
  logic                  wr_go, rd_go;
  logic [CW+AW-1:0]      waddr, raddr;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;

  // Channel numbers beyond NUM_CH are ignored when NUM_CH is not a power of two.
  if (NUM_CH == (2 ** CW)) begin : g_ch_all
    assign wr_ch_ok = 1'b1;
    assign rd_ch_ok = 1'b1;
  end else begin : g_ch_chk
    assign wr_ch_ok = 32'(wr_ch) < NUM_CH;
    assign rd_ch_ok = 32'(rd_ch) < NUM_CH;
  end

  // Decisions use start-of-cycle flags, so a same-cycle write never feeds a read.
  assign wr_go = wr_en && wr_ch_ok && !full_q[wr_ch] && !sw_rst;
  assign rd_go = rd_en && rd_ch_ok && !empty_q[rd_ch] && !sw_rst;
  assign waddr = {wr_ch, wptr_q[wr_ch][AW-1:0]};
  assign raddr = {rd_ch, rptr_q[rd_ch][AW-1:0]};

  always_comb begin
    ovf_new = '0;
    udf_new = '0;
    if (wr_en && wr_ch_ok && full_q[wr_ch] && !sw_rst) ovf_new[wr_ch] = 1'b1;
    if (rd_en && rd_ch_ok && empty_q[rd_ch] && !sw_rst) udf_new[rd_ch] = 1'b1;

    for (int unsigned c = 0; c < NUM_CH; c++) begin
      wptr_d[c] = wptr_q[c];
      rptr_d[c] = rptr_q[c];
      if (sw_rst) begin
        wptr_d[c] = '0;
        rptr_d[c] = '0;
      end else begin
        if (wr_go && (wr_ch == CW'(c))) wptr_d[c] = wptr_q[c] + ptr_t'(1);
        if (rd_go && (rd_ch == CW'(c))) rptr_d[c] = rptr_q[c] + ptr_t'(1);
      end
      // Flags are registered from the next pointers so they are valid right after the edge.
      level[c]    = wptr_d[c] - rptr_d[c];
      empty_d[c]  = (wptr_d[c] == rptr_d[c]);
      full_d[c]   = (wptr_d[c][AW] != rptr_d[c][AW]) &&
                    (wptr_d[c][AW-1:0] == rptr_d[c][AW-1:0]);
      afull_d[c]  = (level[c] >= AfLevel);
      aempty_d[c] = (level[c] <= AeLevel);
    end

    // A new error in the same cycle as err_clr survives the clear.
    if (STICKY_ERROR) begin
      ovf_d = (err_clr ? '0 : ovf_q) | ovf_new;
      udf_d = (err_clr ? '0 : udf_q) | udf_new;
    end else begin
      ovf_d = ovf_new;
      udf_d = udf_new;
    end
    if (sw_rst) begin
      ovf_d = '0;
      udf_d = '0;
    end
  end

  always_ff @(posedge clk or negedge hwrst) begin
    if (!hwrst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
      end
      full_q   <= '0;
      empty_q  <= '1;
      afull_q  <= '0;
      aempty_q <= '1;
      ovf_q    <= '0;
      udf_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
      end
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      rvalid_q <= rd_go;
      if (rd_go) rdata_q <= mem[raddr];
    end
  end

  // Storage is not reset; empty gating keeps stale entries from being read.
  always_ff @(posedge clk) begin
    if (wr_go) mem[waddr] <= wdata;
  end

`ifdef SYNC_FIFO_MC_RD_PIPE_EN
  logic [DATA_WIDTH-1:0] rdata_p_q;
  logic                  rvalid_p_q;

  always_ff @(posedge clk or negedge hwrst) begin
    if (!hwrst) begin
      rdata_p_q  <= '0;
      rvalid_p_q <= 1'b0;
    end else begin
      rvalid_p_q <= rvalid_q && !sw_rst;
      if (rvalid_q && !sw_rst) rdata_p_q <= rdata_q;
    end
  end

  assign rdata  = rdata_p_q;
  assign rvalid = rvalid_p_q;
`else
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign wr_overflow  = ovf_q;
  assign rd_underflow = udf_q;

endmodule
